motor_drive: RTL and testbench

- Consumer of the control loop's signed speed/turn commands; turns them into differential-drive H-bridge signals (PWM plus two direction pins per wheel).
- Mixes speed and turn into left/right wheel targets, then applies per-period slew limiting and a dead-time coast on direction reversal.
- Includes a command watchdog that stops the motors when commands stop arriving.
- Sits between control and the board-level motor driver pins.

---
 rtl/motor_pkg.sv | 35 +++
 rtl/motor_channel.sv | 109 ++++++++++
 rtl/motor_drive.sv | 118 +++++++++++
 tb/tb_motor_drive.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared types and constants for the differential motor drive.
//   dir_t        : wheel direction (forward / reverse)
//   chan_state_t : per-wheel channel state (running / dead-time coast)
//   target_t     : wheel target as sign + 8-bit magnitude
//   mix_sat()    : saturates a 10-bit signed mix result to [-255, +255]
package motor_pkg;

  localparam int PWM_BITS = 8;
  localparam int DUTY_MAX = 255;

  localparam logic [1:0] BR_FWD   = 2'b10;
  localparam logic [1:0] BR_REV   = 2'b01;
  localparam logic [1:0] BR_COAST = 2'b00;

  typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dir_t;
  typedef enum logic {CH_RUN = 1'b0, CH_DEAD = 1'b1} chan_state_t;

  typedef struct packed {
    logic       neg;
    logic [7:0] mag;
  } target_t;

  // Symmetric saturation: -512 maps to magnitude 255, not 256.
  function automatic target_t mix_sat(input logic signed [9:0] v);
    target_t          t;
    logic signed [9:0] n;
    n     = -v;
    t.neg = v[9];
    if (v > 10'sd255 || v < -10'sd255) t.mag = 8'd255;
    else if (v[9])                     t.mag = n[7:0];
    else                               t.mag = v[7:0];
    return t;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge wheel channel.
//   Ports: clk_in, rst_in (async active-low), boundary_i (PWM period boundary),
//          tgt_neg_i / tgt_mag_i (target sign and magnitude), count_i (PWM count),
//          pwm_o, in1_o / in2_o (bridge direction pins, registered).
//   Duty slews toward the target once per period; a direction reversal first
//   ramps the duty to 0, then coasts for DEAD_PERIODS full periods.
//
//   state   | meaning
//   CH_RUN  | duty tracks target magnitude in the current direction
//   CH_DEAD | forced coast between directions, dead_cnt counts boundaries
module motor_channel
  import motor_pkg::*;
#(
  parameter int SLEW         = 16,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       boundary_i,
  input  logic       tgt_neg_i,
  input  logic [7:0] tgt_mag_i,
  input  logic [7:0] count_i,
  output logic       pwm_o,
  output logic       in1_o,
  output logic       in2_o
);

  localparam int         DW     = $clog2(DEAD_PERIODS + 1);
  localparam logic [7:0] SLEW_V = 8'(SLEW);

  chan_state_t   state_q, state_d;
  dir_t          dir_q, dir_d, tgt_dir;
  logic [7:0]    duty_q, duty_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          pwm_q, pwm_d;
  logic [1:0]    br_q, br_d;

  function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] r;
    if (tgt > cur) r = ((tgt - cur) > SLEW_V) ? cur + SLEW_V : tgt;
    else           r = ((cur - tgt) > SLEW_V) ? cur - SLEW_V : tgt;
    return r;
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= CH_RUN;
      dir_q   <= DIR_FWD;
      duty_q  <= '0;
      dead_q  <= '0;
      pwm_q   <= 1'b0;
      br_q    <= BR_COAST;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      pwm_q   <= pwm_d;
      br_q    <= br_d;
    end
  end

  assign tgt_dir = tgt_neg_i ? DIR_REV : DIR_FWD;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    if (boundary_i) begin
      case (state_q)
        CH_RUN: begin
          if (tgt_mag_i == 8'd0 || tgt_dir == dir_q) begin
            duty_d = slew_to(duty_q, tgt_mag_i);
          end else if (duty_q == 8'd0) begin
            state_d = CH_DEAD;
            dead_d  = DW'(DEAD_PERIODS);
          end else begin
            duty_d = slew_to(duty_q, 8'd0);
          end
        end
        CH_DEAD: begin
          duty_d = 8'd0;
          dead_d = dead_q - DW'(1);
          // Leaving dead time: adopt the target sign (zero keeps direction)
          // and take the first ramp step in the same boundary.
          if (dead_q == DW'(1)) begin
            state_d = CH_RUN;
            if (tgt_mag_i != 8'd0) dir_d = tgt_dir;
            duty_d = slew_to(8'd0, tgt_mag_i);
          end
        end
        default: state_d = CH_RUN;
      endcase
    end
  end

  always_comb begin
    pwm_d = (count_i < duty_q);
    if (state_q == CH_DEAD || duty_q == 8'd0) br_d = BR_COAST;
    else if (dir_q == DIR_FWD)               br_d = BR_FWD;
    else                                     br_d = BR_REV;
  end

  assign pwm_o = pwm_q;
  assign in1_o = br_q[1];
  assign in2_o = br_q[0];

endmodule

// File: rtl/motor_drive.sv
// motor_drive: differential-drive H-bridge controller.
//   Ports: clk_in, rst_in (async active-low), valid_in strobe with signed
//          speed/turn commands; pwm/in1/in2 per wheel, period_out boundary
//          strobe, timeout_out while the command watchdog has expired.
//   Owns speed/turn mixing with saturation, the PWM timebase and the
//   watchdog; each wheel is a motor_channel.
module motor_drive
  import motor_pkg::*;
#(
  parameter int PWM_DIV         = 4,
  parameter int SLEW            = 16,
  parameter int DEAD_PERIODS    = 2,
  parameter int TIMEOUT_PERIODS = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       valid_in,
  input  logic [8:0] speed,
  input  logic [8:0] turn,
  output logic       pwm_l_out,
  output logic       pwm_r_out,
  output logic       in1_l_out,
  output logic       in2_l_out,
  output logic       in1_r_out,
  output logic       in2_r_out,
  output logic       period_out,
  output logic       timeout_out
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_PERIODS + 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                tick, boundary;
  logic [TW-1:0]       wd_q, wd_d;
  logic                tmo_q, tmo_d;
  logic                per_q;
  target_t             tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [9:0]          mix_l, mix_r;

  assign tick     = (presc_q == PW'(PWM_DIV - 1));
  assign boundary = tick && (cnt_q == PWM_BITS'(DUTY_MAX));
  assign presc_d  = tick ? '0 : presc_q + PW'(1);
  assign cnt_d    = tick ? cnt_q + PWM_BITS'(1) : cnt_q;

  // Sign-extend to 10 bits so the full +-512 range of the sum is exact.
  assign mix_l = {speed[8], speed} + {turn[8], turn};
  assign mix_r = {speed[8], speed} - {turn[8], turn};

  always_comb begin
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    if (valid_in) begin
      wd_d    = '0;
      tmo_d   = 1'b0;
      tgt_l_d = mix_sat(mix_l);
      tgt_r_d = mix_sat(mix_r);
    end else if (boundary && wd_q != TW'(TIMEOUT_PERIODS)) begin
      wd_d = wd_q + TW'(1);
      if (wd_q == TW'(TIMEOUT_PERIODS - 1)) begin
        tmo_d   = 1'b1;
        tgt_l_d = '0;
        tgt_r_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      presc_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      per_q   <= 1'b0;
      tgt_l_q <= '0;
      tgt_r_q <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      per_q   <= boundary;
      tgt_l_q <= tgt_l_d;
      tgt_r_q <= tgt_r_d;
    end
  end

  motor_channel #(.SLEW(SLEW), .DEAD_PERIODS(DEAD_PERIODS)) u_left (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .boundary_i(boundary),
    .tgt_neg_i (tgt_l_q.neg),
    .tgt_mag_i (tgt_l_q.mag),
    .count_i   (cnt_q),
    .pwm_o     (pwm_l_out),
    .in1_o     (in1_l_out),
    .in2_o     (in2_l_out)
  );

  motor_channel #(.SLEW(SLEW), .DEAD_PERIODS(DEAD_PERIODS)) u_right (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .boundary_i(boundary),
    .tgt_neg_i (tgt_r_q.neg),
    .tgt_mag_i (tgt_r_q.mag),
    .count_i   (cnt_q),
    .pwm_o     (pwm_r_out),
    .in1_o     (in1_r_out),
    .in2_o     (in2_r_out)
  );

  assign period_out  = per_q;
  assign timeout_out = tmo_q;

endmodule

// File: tb/tb_motor_drive.sv
module tb_motor_drive;

  localparam int SLEW = 16;
  localparam int DEAD = 2;
  localparam int TMO  = 8;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b0;
  logic              valid_in = 1'b0;
  logic signed [8:0] speed = '0;
  logic signed [8:0] turn  = '0;
  logic pwm_l_out, pwm_r_out, in1_l_out, in2_l_out, in1_r_out, in2_r_out;
  logic period_out, timeout_out;

  int checks = 0;
  int failures = 0;
  int printed = 0;
  bit chk_en = 1'b0;
  int cmd_s = 0, cmd_t = 0;

  motor_drive #(.PWM_DIV(1), .SLEW(SLEW), .DEAD_PERIODS(DEAD), .TIMEOUT_PERIODS(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_n), .valid_in(valid_in), .speed(speed), .turn(turn),
    .pwm_l_out(pwm_l_out), .pwm_r_out(pwm_r_out),
    .in1_l_out(in1_l_out), .in2_l_out(in2_l_out),
    .in1_r_out(in1_r_out), .in2_r_out(in2_r_out),
    .period_out(period_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural model ----------------
  // Time is counted in clock edges since reset release; the period phase is
  // edge count mod 256. Duties are plain integers, direction is +1 / -1.
  int m_edge = 0, m_tl = 0, m_tr = 0, m_since = 0;
  int m_duty[2] = '{0, 0};
  int m_dir[2]  = '{1, 1};
  int m_dead[2] = '{0, 0};
  logic       e_pwm[2] = '{1'b0, 1'b0};
  logic [1:0] e_br[2]  = '{2'b00, 2'b00};
  logic       e_per = 1'b0, e_tmo = 1'b0;

  function automatic int clip(input int v);
    return (v > 255) ? 255 : ((v < -255) ? -255 : v);
  endfunction

  task automatic model_step(input int c, input int t);
    int mag, sgn;
    mag = (t < 0) ? -t : t;
    sgn = (t < 0) ? -1 : 1;
    if (m_dead[c] > 0) begin
      m_dead[c]--;
      if (m_dead[c] == 0) begin
        if (mag != 0) m_dir[c] = sgn;
        m_duty[c] = (mag < SLEW) ? mag : SLEW;
      end
    end else if (mag == 0 || sgn == m_dir[c]) begin
      if (mag > m_duty[c]) m_duty[c] = (mag - m_duty[c] > SLEW) ? m_duty[c] + SLEW : mag;
      else                 m_duty[c] = (m_duty[c] - mag > SLEW) ? m_duty[c] - SLEW : mag;
    end else if (m_duty[c] == 0) begin
      m_dead[c] = DEAD;
    end else begin
      m_duty[c] = (m_duty[c] > SLEW) ? m_duty[c] - SLEW : 0;
    end
  endtask

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0; m_tl = 0; m_tr = 0; m_since = 0;
      for (int c = 0; c < 2; c++) begin
        m_duty[c] = 0; m_dir[c] = 1; m_dead[c] = 0; e_pwm[c] = 1'b0; e_br[c] = 2'b00;
      end
      e_per = 1'b0; e_tmo = 1'b0;
    end else begin
      int ph;
      ph = m_edge % 256;
      for (int c = 0; c < 2; c++) begin
        e_pwm[c] = (ph < m_duty[c]);
        e_br[c]  = (m_dead[c] > 0 || m_duty[c] == 0) ? 2'b00 : ((m_dir[c] > 0) ? 2'b10 : 2'b01);
      end
      e_per = (ph == 255);
      if (ph == 255) begin
        model_step(0, m_tl);
        model_step(1, m_tr);
      end
      if (valid_in) begin
        m_since = 0;
        m_tl = clip(int'(speed) + int'(turn));
        m_tr = clip(int'(speed) - int'(turn));
      end else if (ph == 255 && m_since < TMO) begin
        m_since++;
        if (m_since == TMO) begin m_tl = 0; m_tr = 0; end
      end
      e_tmo = (m_since >= TMO);
      m_edge++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] last_dir[2] = '{2'b00, 2'b00};
  int         coast_run[2] = '{0, 0};

  always @(negedge clk_in) begin
    if (chk_en) begin
      logic [7:0] act, exp;
      logic [1:0] br[2];
      act = {pwm_l_out, pwm_r_out, in1_l_out, in2_l_out, in1_r_out, in2_r_out, period_out, timeout_out};
      exp = {e_pwm[0], e_pwm[1], e_br[0], e_br[1], e_per, e_tmo};
      checks++;
      if (act !== exp) begin
        failures++;
        if (printed < 20) begin
          printed++;
          $display("FAIL model_cmp t=%0t actual=%b expected=%b", $time, act, exp);
        end
      end
      br[0] = {in1_l_out, in2_l_out};
      br[1] = {in1_r_out, in2_r_out};
      for (int c = 0; c < 2; c++) begin
        if (!rst_n) begin
          last_dir[c] = 2'b00; coast_run[c] = 0;
        end else if (br[c] == 2'b00) begin
          coast_run[c]++;
        end else begin
          if (last_dir[c] != 2'b00 && last_dir[c] != br[c]) begin
            checks++;
            if (coast_run[c] < DEAD * 256) begin
              failures++;
              $display("FAIL dead_gap ch=%0d actual=%0d required_min=%0d", c, coast_run[c], DEAD * 256);
            end
          end
          last_dir[c] = br[c]; coast_run[c] = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in); #2;
    rst_n = 1'b0; valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_outputs", {pwm_l_out, pwm_r_out, in1_l_out, in2_l_out, in1_r_out,
                          in2_r_out, period_out, timeout_out}, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_period(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (!period_out && cyc < 400);
    if (cyc >= 400) chk("period_timeout", cyc, 256);
  endtask

  // Sums one full PWM period starting at a period_out sample; optionally
  // re-sends the current command, which then takes effect next period.
  task automatic measure(input bit resend, output int hl, output int hr,
                         output int bl, output int br, output int tmo0);
    hl = 0; hr = 0; bl = 0; br = 0;
    tmo0 = int'(timeout_out);
    for (int j = 0; j < 256; j++) begin
      valid_in = resend && (j == 0);
      speed = 9'(cmd_s);
      turn  = 9'(cmd_t);
      @(negedge clk_in);
      hl += int'(pwm_l_out);
      hr += int'(pwm_r_out);
      if (j == 128) begin
        bl = int'({in1_l_out, in2_l_out});
        br = int'({in1_r_out, in2_r_out});
      end
    end
    valid_in = 1'b0;
    chk("period_end", int'(period_out), 1);
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int cyc, hl, hr, bl, br, t0;
    int rev_l[11];
    int rev_b[11];
    rev_l = '{64, 48, 32, 16, 0, 0, 0, 16, 32, 48, 64};
    rev_b = '{2, 2, 2, 2, 0, 0, 0, 1, 1, 1, 1};

    repeat (2) @(negedge clk_in);
    chk_en = 1'b1;

    // Reset and timebase.
    do_reset();
    wait_period(cyc); chk("first_period", cyc, 256);
    wait_period(cyc); chk("period_interval", cyc, 256);

    // +100 straight: ramp in steps of 16 to 100.
    do_reset();
    wait_period(cyc);
    cmd_s = 100; cmd_t = 0;
    for (int k = 1; k <= 9; k++) begin
      measure(1'b1, hl, hr, bl, br, t0);
      chk($sformatf("fwd100_l k=%0d", k), hl, (k == 1) ? 0 : mn(16 * (k - 1), 100));
      chk($sformatf("fwd100_r k=%0d", k), hr, (k == 1) ? 0 : mn(16 * (k - 1), 100));
      chk($sformatf("fwd100_pins k=%0d", k), bl, (k == 1) ? 0 : 2);
    end

    // +100/+200: left saturates to 255, right reverses through dead time.
    do_reset();
    wait_period(cyc);
    cmd_s = 100; cmd_t = 200;
    for (int k = 1; k <= 17; k++) begin
      measure(1'b1, hl, hr, bl, br, t0);
      chk($sformatf("mix_l k=%0d", k), hl, (k == 1) ? 0 : mn(16 * (k - 1), 255));
      chk($sformatf("mix_r k=%0d", k), hr, (k <= 3) ? 0 : mn(16 * (k - 3), 100));
      chk($sformatf("mix_pins_r k=%0d", k), br, (k <= 3) ? 0 : 1);
    end

    // +64 then -64: ramp down, two dead periods, ramp up reversed.
    do_reset();
    wait_period(cyc);
    cmd_s = 64; cmd_t = 0;
    for (int k = 1; k <= 6; k++) begin
      measure(1'b1, hl, hr, bl, br, t0);
      chk($sformatf("pre_rev k=%0d", k), hl, (k == 1) ? 0 : mn(16 * (k - 1), 64));
    end
    cmd_s = -64;
    for (int k = 0; k < 11; k++) begin
      measure(1'b1, hl, hr, bl, br, t0);
      chk($sformatf("rev_duty k=%0d", k + 7), hl, rev_l[k]);
      chk($sformatf("rev_pins_l k=%0d", k + 7), bl, rev_b[k]);
      chk($sformatf("rev_pins_r k=%0d", k + 7), br, rev_b[k]);
    end

    // -256/-256: left saturates to -255, right 0.
    do_reset();
    wait_period(cyc);
    cmd_s = -256; cmd_t = -256;
    for (int k = 1; k <= 20; k++) begin
      measure(1'b1, hl, hr, bl, br, t0);
      chk($sformatf("neg_l k=%0d", k), hl, (k <= 3) ? 0 : mn(16 * (k - 3), 255));
      chk($sformatf("neg_pins_l k=%0d", k), bl, (k <= 3) ? 0 : 1);
      chk($sformatf("neg_r k=%0d", k), hr + br, 0);
    end

    // Watchdog: +80 then silence.
    do_reset();
    wait_period(cyc);
    cmd_s = 80; cmd_t = 0;
    for (int k = 1; k <= 7; k++) begin
      measure(1'b1, hl, hr, bl, br, t0);
      chk($sformatf("wd_ramp k=%0d", k), hl, (k == 1) ? 0 : mn(16 * (k - 1), 80));
    end
    for (int k = 8; k <= 21; k++) begin
      measure(1'b0, hl, hr, bl, br, t0);
      chk($sformatf("wd_tmo k=%0d", k), t0, (k >= 15) ? 1 : 0);
      chk($sformatf("wd_duty k=%0d", k), hl, (k <= 15) ? 80 : ((80 - 16 * (k - 15) > 0) ? 80 - 16 * (k - 15) : 0));
      chk($sformatf("wd_pins k=%0d", k), bl, (k <= 19) ? 2 : 0);
    end
    chk("wd_still_high", int'(timeout_out), 1);
    cmd_s = 10;
    speed = 9'(cmd_s); turn = '0; valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    chk("wd_cleared", int'(timeout_out), 0);
    repeat (600) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
